// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bubble instruction, condition codes, opcodes and
// instruction field positions used by the fetch/decode front end.
package cpu_pkg;

    localparam logic [31:0] NV_BUBBLE = 32'hF000_0000;

    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
        CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
        CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
        CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
    } condCode_t;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10
    } opCode_t;

    localparam int COND_HI  = 31, COND_LO  = 28;
    localparam int OP_HI    = 27, OP_LO    = 26;
    localparam int FUNCT_HI = 25, FUNCT_LO = 20;
    localparam int RN_HI    = 19, RN_LO    = 16;
    localparam int RD_HI    = 15, RD_LO    = 12;
    localparam int RM_HI    = 3,  RM_LO    = 0;
    localparam int IMM_HI   = 23, IMM_LO   = 0;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous clear to CLR_VAL beats enable.
module pipe_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= CLR_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register with redirect/stall priority, IF/ID register,
// decoded instruction fields and the architectural NZCV flag register.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenE,
    input  logic [WIDTH-1:0] BranchTargetE,
    input  logic             PCSrcW,
    input  logic [WIDTH-1:0] ResultW,
    output logic [WIDTH-1:0] InstrAddr,
    input  logic [31:0]      InstrData,
    output logic [WIDTH-1:0] PCF,
    output logic [31:0]      InstrD,
    output logic [WIDTH-1:0] PCPlus8D,
    output logic             ValidD,
    output logic [3:0]       Cond,
    output logic [1:0]       Op,
    output logic [5:0]       Funct,
    output logic [3:0]       Rn,
    output logic [3:0]       Rd,
    output logic [3:0]       Rm,
    output logic [23:0]      Imm24,
    input  logic             FlagWriteE,
    input  logic             CondExE,
    input  logic [3:0]       ALUFlagsE,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam int IFID_W = 32 + WIDTH + 1;
    localparam logic [IFID_W-1:0] IFID_CLR = {NV_BUBBLE, {WIDTH{1'b0}}, 1'b0};

    logic [WIDTH-1:0] pcNext, pcSel, pcPlus4F, pcPlus4D;
    logic             redirect;
    logic [3:0]       flags;

    assign pcPlus4F = PCF + WIDTH'(4);
    assign redirect = PCSrcW | BranchTakenE;

    always_comb begin
        pcSel = pcPlus4F;
        if (PCSrcW)
            pcSel = ResultW;
        else if (BranchTakenE)
            pcSel = BranchTargetE;
        pcNext = {pcSel[WIDTH-1:2], 2'b00};
    end

    // A redirect must land even while fetch is stalled.
    pipe_reg #(.WIDTH(WIDTH), .CLR_VAL('0)) pcReg (
        .clk (clk),
        .clr (reset),
        .en  (~StallF | redirect),
        .d   (pcNext),
        .q   (PCF)
    );

    pipe_reg #(.WIDTH(IFID_W), .CLR_VAL(IFID_CLR)) ifIdReg (
        .clk (clk),
        .clr (reset | FlushD),
        .en  (~StallD),
        .d   ({InstrData, pcPlus4F, 1'b1}),
        .q   ({InstrD, pcPlus4D, ValidD})
    );

    pipe_reg #(.WIDTH(4), .CLR_VAL(4'b0000)) flagReg (
        .clk (clk),
        .clr (reset),
        .en  (FlagWriteE & CondExE),
        .d   (ALUFlagsE),
        .q   (flags)
    );

    assign InstrAddr    = PCF;
    assign PCPlus8D     = pcPlus4D + WIDTH'(4);
    assign {n, z, c, v} = flags;

    assign Cond  = InstrD[COND_HI:COND_LO];
    assign Op    = InstrD[OP_HI:OP_LO];
    assign Funct = InstrD[FUNCT_HI:FUNCT_LO];
    assign Rn    = InstrD[RN_HI:RN_LO];
    assign Rd    = InstrD[RD_HI:RD_LO];
    assign Rm    = InstrD[RM_HI:RM_LO];
    assign Imm24 = InstrD[IMM_HI:IMM_LO];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the PC and data width.
REQ-002 The block SHALL have clocking and control ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- StallF  in  1  hold PC
- StallD  in  1  hold IF/ID register
- FlushD  in  1  bubble IF/ID register
REQ-003 The block SHALL have PC redirect ports:
- BranchTakenE  in  1  branch resolved taken in execute
- BranchTargetE  in  WIDTH  branch target
- PCSrcW  in  1  writeback writes PC
- ResultW  in  WIDTH  writeback PC value
REQ-004 The block SHALL have instruction memory and pipeline output ports:
- InstrAddr  out  WIDTH  fetch address, equal to PCF
- InstrData  in  32  combinational read data for InstrAddr
- PCF  out  WIDTH  current PC
- InstrD  out  32  decode-stage instruction
- PCPlus8D  out  WIDTH  r15 read value
- ValidD  out  1  InstrD is a real fetch, not a bubble
REQ-005 The block SHALL have decoded field outputs, combinational from InstrD:
- Cond  out  4  = InstrD[31:28]
- Op  out  2  = InstrD[27:26]
- Funct  out  6  = InstrD[25:20]
- Rn  out  4  = InstrD[19:16]
- Rd  out  4  = InstrD[15:12]
- Rm  out  4  = InstrD[3:0]
- Imm24  out  24  = InstrD[23:0]
REQ-006 The block SHALL have flag ports:
- FlagWriteE  in  1
- CondExE  in  1
- ALUFlagsE  in  4  {N,Z,C,V}
- n, z, c, v  out  1 each, registered flags

Function
REQ-007 PCF SHALL update every cycle. Next-PC priority, highest first:
- PCSrcW -> ResultW
- BranchTakenE -> BranchTargetE
- StallF -> hold
- otherwise PCF+4
REQ-008 Any redirect (PCSrcW or BranchTakenE) SHALL override StallF in the same cycle.
REQ-009 The two low bits of every value loaded into PCF SHALL be forced to 0.
REQ-010 PC arithmetic SHALL be modulo 2^WIDTH: PCF=FFFFFFFC with no stall or redirect SHALL give PCF=00000000 next cycle.
REQ-011 The IF/ID register (InstrD, PCPlus4D, ValidD) SHALL be loaded with priority FlushD > StallD > load:
- Load: InstrData, PCF+4, and ValidD=1.
- FlushD: InstrD=F0000000 (NV bubble, never executes) and ValidD=0.
- StallD: all three values held.
REQ-012 PCPlus8D SHALL equal PCPlus4D+4 (mod 2^WIDTH), combinational.
REQ-013 Fetch latency SHALL be one cycle: the word at PCF in cycle t appears on InstrD in cycle t+1 unless stalled or flushed.
REQ-014 The flag register SHALL load {n,z,c,v} from ALUFlagsE on a clock edge where FlagWriteE and CondExE are both 1, and SHALL hold otherwise.
REQ-015 With StallF=1 and StallD=1 and no redirect, PCF and InstrD SHALL hold indefinitely with no change.

Reset
REQ-016 While reset=1 at a clock edge, the block SHALL set:
- PCF=0
- InstrD=F0000000
- PCPlus4D=0
- ValidD=0
- n=z=c=v=0
Reset SHALL override stall, flush and redirect.
REQ-017 On the first edge after reset deasserts, the block SHALL fetch address 0: PCF advances to 4 and InstrD captures the word at address 0.
REQ-018 Reset asserted mid-operation SHALL discard any pending redirect or stall in that same cycle.

Structure
REQ-019 The shared package cpu_pkg SHALL define:
- the NV bubble constant F0000000
- condition-code constants
- Op encodings (DP=00, MEM=01, BR=10)
- instruction field bit positions
REQ-020 A single sub-module pipe_reg (WIDTH-parameterised register with synchronous clear, enable and clear value) SHALL implement the PC, IF/ID and flag registers.

Verification
REQ-021 Reset then run 3 cycles with memory word at address n = n -> PCF 4, 8, C; InstrD 0, 4, 8; ValidD=1.
REQ-022 PCF=10, StallF=StallD=1 for 2 cycles -> PCF stays 10 and InstrD stays 0C; on release PCF=14.
REQ-023 PCF=20, BranchTakenE=1, BranchTargetE=100, FlushD=1 with StallF=1 -> next cycle PCF=100 and InstrD=F0000000 with ValidD=0.
REQ-024 PCSrcW=1, ResultW=203, BranchTakenE=1, BranchTargetE=400 in the same cycle -> PCF=200.
REQ-025 Flags:
- FlagWriteE=1, CondExE=0, ALUFlagsE=1010 -> flags stay 0000.
- Next cycle, CondExE=1 -> {n,z,c,v}=1010.
REQ-026 PCF=FFFFFFFC with no stall -> next PCF=0, and PCPlus8D=00000004 when that instruction reaches decode.
